// File: rtl/audio_framer.sv
`timescale 1ns/1ps
// audio_framer
//   Pre-emphasises a 14-bit signed sample stream, y = x - x_prev + (x_prev >>> PREEMPH_SHIFT),
//   and packs the results into FRAME_LEN-word frames in a two-bank ping-pong RAM. Completed
//   frames stream out in capture order over a valid/ready interface.
//   Optional build macro: FRAME_ENERGY_EN (per-frame sum of |y| on frame_energy; else tied to 0).
// Ports:
//   gCLK_50MHz, gRST_N      clock, asynchronous active-low reset
//   enable                  framing enable; low discards any partial frame
//   sample_in/sample_valid  input sample and its one-cycle strobe
//   frame_data/frame_valid/frame_ready/frame_last  output stream, frame_last on word FRAME_LEN-1
//   overrun_cnt             saturating count of samples dropped because both banks were full
//   frame_energy            energy of the frame being streamed
module audio_framer #(
  parameter int DATA_W        = 14,
  parameter int OUT_W         = 16,
  parameter int FRAME_LEN     = 256,
  parameter int ADDR_W        = 8,
  parameter int PREEMPH_SHIFT = 5
) (
  input  logic              gCLK_50MHz,
  input  logic              gRST_N,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [OUT_W-1:0]  frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_last,
  output logic [7:0]        overrun_cnt,
  output logic [23:0]       frame_energy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} rd_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  logic [OUT_W-1:0] mem [2*FRAME_LEN];

  // Pre-emphasis
  logic [DATA_W-1:0]       x_prev;
  logic signed [OUT_W-1:0] x_ext, xp_ext, y;

  always_comb begin
    x_ext  = {{(OUT_W-DATA_W){sample_in[DATA_W-1]}}, sample_in};
    xp_ext = {{(OUT_W-DATA_W){x_prev[DATA_W-1]}}, x_prev};
    y      = x_ext - xp_ext + (xp_ext >>> PREEMPH_SHIFT);
  end

  // Writer: pointer/bank/drop decided in the strobe cycle, RAM written one cycle later
  logic [ADDR_W-1:0]       wr_ptr, wr_addr_q;
  logic                    wr_bank, wr_bank_q, wr_en_q;
  logic signed [OUT_W-1:0] y_q;
  logic [1:0]              bank_full;
  logic                    release_bank;

  always_ff @(posedge gCLK_50MHz or negedge gRST_N) begin
    if (!gRST_N) begin
      wr_ptr      <= '0;
      wr_bank     <= 1'b0;
      x_prev      <= '0;
      overrun_cnt <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_bank_q   <= 1'b0;
      y_q         <= '0;
    end else begin
      wr_en_q   <= enable & sample_valid & ~bank_full[wr_bank];
      wr_addr_q <= wr_ptr;
      wr_bank_q <= wr_bank;
      y_q       <= y;
      if (!enable) begin
        wr_ptr <= '0;
        x_prev <= '0;
      end else if (sample_valid) begin
        x_prev <= sample_in;
        if (bank_full[wr_bank]) begin
          if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 8'd1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_ADDR) wr_bank <= ~wr_bank;
        end
      end
    end
  end

  always_ff @(posedge gCLK_50MHz) begin
    if (wr_en_q) mem[{wr_bank_q, wr_addr_q}] <= y_q;
  end

  // Full flags: the reader only frees full banks and the writer never targets a full bank,
  // so set and clear never address the same bank in one cycle.
  always_ff @(posedge gCLK_50MHz or negedge gRST_N) begin
    if (!gRST_N) begin
      bank_full <= '0;
    end else begin
      if (release_bank) bank_full[rd_bank] <= 1'b0;
      if (wr_en_q && (wr_addr_q == LAST_ADDR)) bank_full[wr_bank_q] <= 1'b1;
    end
  end

  // Reader
  rd_state_t         state, state_nx;
  logic              rd_bank, rd_en;
  logic [ADDR_W-1:0] rd_ptr, rd_addr;

  always_ff @(posedge gCLK_50MHz or negedge gRST_N) begin
    if (!gRST_N) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    rd_en        = 1'b0;
    rd_addr      = rd_ptr;
    release_bank = 1'b0;
    case (state)
      S_IDLE:  if (bank_full[rd_bank]) state_nx = S_LOAD;
      S_LOAD: begin
        rd_en    = 1'b1;
        rd_addr  = '0;
        state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (frame_ready) begin
          if (frame_last) begin
            release_bank = 1'b1;
            state_nx     = bank_full[~rd_bank] ? S_LOAD : S_IDLE;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The RAM read register is the output register: it only advances on a handshake,
  // so data is held under backpressure and the next word appears without a bubble.
  always_ff @(posedge gCLK_50MHz or negedge gRST_N) begin
    if (!gRST_N) begin
      rd_ptr     <= '0;
      rd_bank    <= 1'b0;
      frame_data <= '0;
      frame_last <= 1'b0;
    end else begin
      if (rd_en) begin
        frame_data <= mem[{rd_bank, rd_addr}];
        frame_last <= (rd_addr == LAST_ADDR);
        rd_ptr     <= rd_addr + 1'b1;
      end else if (release_bank) begin
        frame_last <= 1'b0;
      end
      if (release_bank) rd_bank <= ~rd_bank;
    end
  end

  assign frame_valid = (state == S_STREAM);

`ifdef FRAME_ENERGY_EN
  logic [23:0]      acc, acc_sum;
  logic [23:0]      energy_lat [2];
  logic [OUT_W-1:0] mag;

  // A write to address 0 starts a new frame, so the running sum restarts there.
  always_comb begin
    mag     = y_q[OUT_W-1] ? -y_q : y_q;
    acc_sum = ((wr_addr_q == '0) ? '0 : acc) + 24'(mag);
  end

  always_ff @(posedge gCLK_50MHz or negedge gRST_N) begin
    if (!gRST_N) begin
      acc           <= '0;
      energy_lat[0] <= '0;
      energy_lat[1] <= '0;
      frame_energy  <= '0;
    end else begin
      if (wr_en_q) begin
        acc <= acc_sum;
        if (wr_addr_q == LAST_ADDR) begin
          energy_lat[wr_bank_q] <= acc_sum;
          acc                   <= '0;
        end
      end
      if (!enable) acc <= '0;
      if (state == S_LOAD) frame_energy <= energy_lat[rd_bank];
    end
  end
`else
  assign frame_energy = '0;
`endif

endmodule

// File: tb/tb_audio_framer.sv
`timescale 1ns/1ps
module tb_audio_framer;
  localparam int FL = 256;

  logic        clk = 1'b0;
  logic        rst_n, enable, sample_valid, frame_ready;
  logic [13:0] sample_in;
  logic [15:0] frame_data;
  logic        frame_valid, frame_last;
  logic [7:0]  overrun_cnt;
  logic [23:0] frame_energy;

  always #10 clk = ~clk;

  audio_framer #(.DATA_W(14), .OUT_W(16), .FRAME_LEN(FL), .ADDR_W(8), .PREEMPH_SHIFT(5)) dut (
    .gCLK_50MHz(clk), .gRST_N(rst_n), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_last(frame_last), .overrun_cnt(overrun_cnt), .frame_energy(frame_energy)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: frames as lists of words, bank occupancy as a count of pending frames
  int   m_xp, m_x, m_y, m_full, m_ovf, m_idx, m_e;
  int   partial[$];
  int   exp_q[$];
  int   exp_e[$];
  int   got[$];
  logic stall_p;
  logic [15:0] held_d;
  logic held_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_xp = 0; m_full = 0; m_ovf = 0; m_idx = 0; stall_p = 1'b0;
      partial.delete(); exp_q.delete(); exp_e.delete();
    end else begin
      if (stall_p) begin
        check("hold_valid", int'(frame_valid), 1);
        check("hold_data", int'({frame_data, frame_last}), int'({held_d, held_l}));
      end
      stall_p = frame_valid && !frame_ready;
      held_d  = frame_data;
      held_l  = frame_last;

      // a sample sees the bank occupancy from before this edge's release
      if (!enable) begin
        partial.delete();
        m_xp = 0;
      end else if (sample_valid) begin
        m_x  = int'($signed(sample_in));
        m_y  = m_x - m_xp + (m_xp >>> 5);
        m_xp = m_x;
        if (m_full == 2) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          partial.push_back(m_y);
          if (partial.size() == FL) begin
            m_e = 0;
            foreach (partial[i]) begin
              exp_q.push_back(partial[i]);
              m_e += (partial[i] < 0) ? -partial[i] : partial[i];
            end
            exp_e.push_back(m_e);
            m_full++;
            partial.delete();
          end
        end
      end

      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_word: got %0d, expected no word (t=%0t)", $signed(frame_data), $time);
        end else begin
          got.push_back(int'($signed(frame_data)));
          check("frame_data", int'($signed(frame_data)), exp_q.pop_front());
          check("frame_last", int'(frame_last), int'(m_idx == FL-1));
`ifdef FRAME_ENERGY_EN
          check("frame_energy", int'(frame_energy), exp_e[0]);
`else
          check("frame_energy", int'(frame_energy), 0);
`endif
          m_idx++;
          if (m_idx == FL) begin
            m_idx = 0;
            m_full--;
            void'(exp_e.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(int x);
    sample_in    = 14'(x);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0; tick(); enable = 1'b1;
  endtask

  task automatic drain(bit rnd);
    int c = 0;
    while (exp_q.size() != 0 && c < 4000) begin
      frame_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      tick();
      c++;
    end
    frame_ready = 1'b1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
    repeat (4) tick();
  endtask

  typedef struct { int x0; int x1; int e0; int e1; } vec_t;
  vec_t tbl[3];

  initial begin
    tbl[0] = '{100, 100, 100, 3};
    tbl[1] = '{-100, -100, -100, -4};
    tbl[2] = '{8191, -8192, 8191, -16128};

    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; frame_ready = 1'b0; sample_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_frame_data", int'(frame_data), 0);
    check("rst_frame_last", int'(frame_last), 0);
    check("rst_overrun", int'(overrun_cnt), 0);
    check("rst_energy", int'(frame_energy), 0);

    // Pre-emphasis vectors: first two words of a fresh frame
    frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      restart();
      got.delete();
      send(tbl[i].x0);
      send(tbl[i].x1);
      repeat (FL-2) send(tbl[i].x1);
      drain(0);
      check("tbl_count", got.size(), FL);
      if (got.size() >= 2) begin
        check("tbl_word0", got[0], tbl[i].e0);
        check("tbl_word1", got[1], tbl[i].e1);
      end
    end

    // Ramp 0..511, two frames back to back
    restart();
    got.delete();
    for (int i = 0; i < 2*FL; i++) send(i);
    drain(0);
    check("ramp_count", got.size(), 2*FL);

    // Step-4 ramp (energy frame)
    restart();
    for (int i = 0; i < FL; i++) send(4*i);
    drain(0);

    // Random samples, random gaps, random backpressure
    restart();
    for (int i = 0; i < 2*FL + 37; i++) begin
      frame_ready = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) tick();
      send(int'($urandom_range(16383)) - 8192);
    end
    drain(1);

    // Overrun: nothing drains while 3*FL+10 samples arrive
    restart();
    frame_ready = 1'b0;
    for (int i = 0; i < 3*FL+10; i++) send(3*i - 1000);
    check("overrun_sat", int'(overrun_cnt), 255);
    check("overrun_model", int'(overrun_cnt), m_ovf);
    got.delete();
    drain(0);
    check("overrun_frames", got.size(), 2*FL);
    for (int i = 0; i < FL; i++) send(int'($urandom_range(16383)) - 8192);
    drain(0);

    // Enable dropped mid-frame
    restart();
    for (int i = 0; i < 100; i++) send(i + 500);
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    got.delete();
    for (int i = 0; i < FL; i++) send(7*i - 900);
    drain(0);
    check("enable_frames", got.size(), FL);

    // Reset mid-stream with a partial frame in flight
    frame_ready = 1'b0;
    for (int i = 0; i < FL; i++) send(i - 128);
    frame_ready = 1'b1;
    for (int i = 0; i < 60; i++) send(2*i);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(frame_valid), 0);
    check("mid_rst_data", int'(frame_data), 0);
    check("mid_rst_last", int'(frame_last), 0);
    check("mid_rst_overrun", int'(overrun_cnt), 0);
    check("mid_rst_energy", int'(frame_energy), 0);
    tick();
    rst_n = 1'b1;
    restart();
    got.delete();
    for (int i = 0; i < FL; i++) send(int'($urandom_range(16383)) - 8192);
    drain(1);
    check("post_rst_frames", got.size(), FL);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
